fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the program counter. It owns the fetch PC, issues word fetches to instruction memory over a valid/ready request channel, and accepts the fixed-order responses.
- Each response is buffered with its PC in a small FIFO and presented to decode over a valid/ready channel.
- A redirect input (branch/jump target from execute) flushes buffered and in-flight instructions and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000: fetch PC value after reset.
- DEPTH, 2: instruction buffer entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid; one response per accepted request, in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).
- inst_valid  output  1  buffer head valid.
- inst_ready  input  1  decode consumes the head.
- inst_data  output  32  head instruction.
- inst_pc  output  32  PC of the head instruction.
- fetch_pc  output  32  next address to be requested (debug).

Behaviour:
- Reset, checked every cycle:
  - fetch_pc = RESET_PC; FSM = IDLE; FIFO count = 0; pointers = 0.
  - While reset is high: imem_req_valid = 0 and inst_valid = 0. inst_data and inst_pc are don't-care.
  - Reset mid-transaction abandons any outstanding request. A response arriving after reset while in IDLE is ignored.
- FSM states: IDLE, WAIT, DROP. One outstanding request maximum.
- Request channel:
  - imem_req_valid = (state==IDLE) && (count<DEPTH) && !redirect_valid && !reset; imem_req_addr = fetch_pc.
  - Accept when valid && ready. On accept: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), state -> WAIT.
  - Valid stays high with a stable address until accepted, unless a redirect changes fetch_pc.
- WAIT:
  - On imem_rsp_valid, push {req_pc, imem_rsp_data}; state -> IDLE.
  - The buffer cannot overflow because count<DEPTH was required at issue.
- Redirect (highest priority):
  - fetch_pc <= {redirect_pc[31:2],2'b00}; FIFO flushed (count=0, pointers=0); a pop in the same cycle is void.
  - From IDLE: stay IDLE; the request resumes the next cycle at the new PC.
  - From WAIT without imem_rsp_valid: go to DROP.
  - From WAIT with imem_rsp_valid in the same cycle: discard the response and go to IDLE.
  - In DROP: stay DROP and take the new PC; if imem_rsp_valid arrives in the same cycle, discard it and go to IDLE.
- DROP: the next imem_rsp_valid is discarded and the state goes to IDLE. No requests are issued while in DROP.
- Output channel:
  - inst_valid = (count!=0); inst_data and inst_pc come from the FIFO head.
  - Pop on inst_valid && inst_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - inst_data and inst_pc stay stable while inst_valid is high and inst_ready is low.
- Latency:
  - Request accepted at cycle 0, response at cycle N, inst_valid high at cycle N+1.
  - After a redirect at cycle R, the earliest request is at R+1 (from IDLE).
- Throughput: at most 1 instruction per 2 cycles (issue, then response).

Test Plan:
- Reset, then memory with ready=1 and 1-cycle response latency, inst_ready=1 -> requests to 0x0, 0x4, 0x8 in order; inst_pc sequence 0x0, 0x4, 0x8 with matching data; fetch_pc = 0xC after the third accept.
- Hold inst_ready=0 -> exactly DEPTH=2 instructions (PC 0x0, 0x4) are buffered and imem_req_valid drops; release ready -> fetch resumes at 0x8 with no loss or duplication.
- imem_req_ready=0 for 3 cycles -> imem_req_valid stays high with imem_req_addr=0x0 held stable; accept on the 4th cycle.
- Redirect to 0x103 while in WAIT, response 2 cycles later -> that response is dropped, the FIFO is empty, and the next request and inst_pc are 0x100.
- Redirect in the same cycle as the WAIT response and a pop, with the FIFO holding 1 entry -> the response is discarded, count=0, inst_valid=0 next cycle, and the next request is at the target.
- RESET_PC=32'hFFFF_FFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0; reset asserted while in WAIT -> imem_req_valid=0 and inst_valid=0, and the stale response is ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, keeps at most one word request in
// flight and buffers in-order responses with their PC for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_pc
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   req_pc_r;
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   data_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          inst_valid_s;
    logic          req_valid_s;
    logic          req_fire_s;
    logic          push_s;
    logic          pop_s;

    // Handshake qualifiers; a redirect voids both the response push and the pop
    always_comb begin
        inst_valid_s = (count_r != CNT_ZERO);
        req_valid_s  = (state_r == ST_IDLE) && (count_r < CNT_FULL) && !redirect_valid && !reset;
        req_fire_s   = req_valid_s && imem_req_ready;
        push_s       = (state_r == ST_WAIT) && imem_rsp_valid && !redirect_valid;
        pop_s        = inst_valid_s && inst_ready && !redirect_valid;
    end

    // Next-state logic; any response seen in WAIT or DROP ends the transaction
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_fire_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next_s = ST_IDLE;
                end else if (redirect_valid) begin
                    state_next_s = ST_DROP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DROP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM state, fetch PC and the PC of the in-flight request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= RESET_PC;
            req_pc_r   <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            if (redirect_valid) begin
                fetch_pc_r <= {redirect_pc[31:2], 2'b00};
            end else if (req_fire_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (req_fire_s) begin
                req_pc_r <= fetch_pc_r;
            end
        end
    end

    // Buffer pointers and occupancy; a redirect empties the buffer
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage; entries are only observed while counted as valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[wr_ptr_r]   <= req_pc_r;
            data_mem_r[wr_ptr_r] <= imem_rsp_data;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = fetch_pc_r;
    assign inst_valid     = inst_valid_s;
    assign inst_data      = data_mem_r[rd_ptr_r];
    assign inst_pc        = pc_mem_r[rd_ptr_r];
    assign fetch_pc       = fetch_pc_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model checks request addresses, a
// monitor checks delivered instructions, directed phases drive the scenarios.
module tb_fetch_unit;
    logic        clk;
    logic        reset_a;
    logic        reset_b;
    logic        sel;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_ready;

    logic        a_req_valid, b_req_valid, a_inst_valid, b_inst_valid;
    logic [31:0] a_req_addr, b_req_addr, a_inst_data, b_inst_data;
    logic [31:0] a_inst_pc, b_inst_pc, a_fetch_pc, b_fetch_pc;

    logic        m_req_valid, m_inst_valid, m_reset;
    logic [31:0] m_req_addr, m_inst_data, m_inst_pc, m_fetch_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } inst_t;

    inst_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          acc_cnt  = 0;
    int          lat      = 1;
    int          base     = 0;
    logic        pend     = 1'b0;
    logic [31:0] pend_addr;
    int          pend_cnt = 0;

    fetch_unit u_dut_a (
        .clk(clk), .reset(reset_a),
        .imem_req_valid(a_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(a_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(a_inst_valid), .inst_ready(inst_ready), .inst_data(a_inst_data),
        .inst_pc(a_inst_pc), .fetch_pc(a_fetch_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_b (
        .clk(clk), .reset(reset_b),
        .imem_req_valid(b_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(b_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(b_inst_valid), .inst_ready(inst_ready), .inst_data(b_inst_data),
        .inst_pc(b_inst_pc), .fetch_pc(b_fetch_pc)
    );

    assign m_req_valid  = sel ? b_req_valid  : a_req_valid;
    assign m_req_addr   = sel ? b_req_addr   : a_req_addr;
    assign m_inst_valid = sel ? b_inst_valid : a_inst_valid;
    assign m_inst_data  = sel ? b_inst_data  : a_inst_data;
    assign m_inst_pc    = sel ? b_inst_pc    : a_inst_pc;
    assign m_fetch_pc   = sel ? b_fetch_pc   : a_fetch_pc;
    assign m_reset      = sel ? reset_b      : reset_a;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], 16'hBEEF};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic exp_inst(input logic [31:0] pc, input logic [31:0] data);
        inst_t e;
        e.pc   = pc;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Memory model: decides at negedge+2 what the coming edge sees
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_DEAD;
        forever begin
            @(negedge clk);
            #2;
            if (pend && pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'hDEAD_DEAD;
                if (pend) pend_cnt--;
            end
            if (m_req_valid && imem_req_ready) begin
                acc_cnt++;
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL req_addr: unexpected request actual=%h expected=none", m_req_addr);
                end else begin
                    check("req_addr", m_req_addr, exp_addr_q.pop_front());
                end
                pend      = 1'b1;
                pend_addr = m_req_addr;
                pend_cnt  = lat - 1;
            end
        end
    end

    // Output monitor: compares every instruction decode actually consumes
    initial begin
        inst_t e;
        forever begin
            @(negedge clk);
            #3;
            if (m_inst_valid && inst_ready && !redirect_valid && !m_reset) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL inst: unexpected instruction actual pc=%h data=%h expected=none",
                             m_inst_pc, m_inst_data);
                end else begin
                    e = exp_q.pop_front();
                    check("inst_pc", m_inst_pc, e.pc);
                    check("inst_data", m_inst_data, e.data);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target);
        int k = 0;
        while (acc_cnt < target && k < 50) begin
            cyc();
            k++;
        end
        check("accept_count", 32'(acc_cnt), 32'(target));
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || pend) && k < 60) begin
            cyc();
            k++;
        end
        check("drain_inst_q", 32'(exp_q.size()), 32'd0);
        check("drain_addr_q", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic do_reset(input logic which);
        sel            = which;
        reset_a        = 1'b1;
        reset_b        = 1'b1;
        imem_req_ready = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        cyc();
        cyc();
        check("rst_req_valid", {31'd0, m_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, m_inst_valid}, 32'd0);
        check("rst_fetch_pc", m_fetch_pc, which ? 32'hFFFF_FFF8 : 32'h0000_0000);
        if (which) reset_b = 1'b0;
        else       reset_a = 1'b0;
    endtask

    initial begin
        sel = 1'b0; reset_a = 1'b1; reset_b = 1'b1;
        imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;

        // Streaming fetch with single-cycle memory
        do_reset(1'b0);
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h8);
        exp_inst(32'h0, 32'h0000_BEEF); exp_inst(32'h4, 32'h0004_BEEF); exp_inst(32'h8, 32'h0008_BEEF);
        base = acc_cnt;
        wait_acc(base + 3);
        imem_req_ready = 1'b0;
        cyc();
        check("fetch_pc_after3", m_fetch_pc, 32'h0000_000C);
        drain();

        // Decode back-pressure fills the buffer and stops requests
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
        exp_inst(32'h0, 32'h0000_BEEF); exp_inst(32'h4, 32'h0004_BEEF); exp_inst(32'h8, 32'h0008_BEEF);
        base = acc_cnt;
        repeat (8) cyc();
        check("bp_req_valid", {31'd0, m_req_valid}, 32'd0);
        check("bp_inst_valid", {31'd0, m_inst_valid}, 32'd1);
        check("bp_accepts", 32'(acc_cnt - base), 32'd2);
        repeat (2) begin
            check("bp_head_pc", m_inst_pc, 32'h0);
            check("bp_head_data", m_inst_data, 32'h0000_BEEF);
            cyc();
        end
        exp_addr_q.push_back(32'h8);
        inst_ready = 1'b1;
        wait_acc(base + 3);
        imem_req_ready = 1'b0;
        drain();

        // Request held stable while memory is not ready
        do_reset(1'b0);
        inst_ready = 1'b1;
        exp_addr_q.push_back(32'h0);
        exp_inst(32'h0, 32'h0000_BEEF);
        base = acc_cnt;
        repeat (3) begin
            cyc();
            check("stall_req_valid", {31'd0, m_req_valid}, 32'd1);
            check("stall_req_addr", m_req_addr, 32'h0);
        end
        check("stall_no_accept", 32'(acc_cnt - base), 32'd0);
        imem_req_ready = 1'b1;
        cyc();
        check("stall_accept", 32'(acc_cnt - base), 32'd1);
        imem_req_ready = 1'b0;
        drain();

        // Redirect while waiting; late response must be dropped
        do_reset(1'b0);
        inst_ready = 1'b1; imem_req_ready = 1'b1; lat = 3;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h100);
        exp_inst(32'h100, 32'h0100_BEEF);
        base = acc_cnt;
        wait_acc(base + 1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        check("drop_req_valid", {31'd0, m_req_valid}, 32'd0);
        check("redir_fetch_pc", m_fetch_pc, 32'h100);
        redirect_valid = 1'b0;
        cyc();
        check("drop_req_valid2", {31'd0, m_req_valid}, 32'd0);
        check("drop_inst_valid", {31'd0, m_inst_valid}, 32'd0);
        cyc();
        check("post_drop_inst_valid", {31'd0, m_inst_valid}, 32'd0);
        check("post_drop_req_valid", {31'd0, m_req_valid}, 32'd1);
        check("post_drop_req_addr", m_req_addr, 32'h100);
        wait_acc(base + 2);
        imem_req_ready = 1'b0;
        drain();
        lat = 1;

        // Redirect coinciding with response and pop, one entry buffered
        do_reset(1'b0);
        imem_req_ready = 1'b1;
        exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4); exp_addr_q.push_back(32'h200);
        exp_inst(32'h200, 32'h0200_BEEF);
        base = acc_cnt;
        wait_acc(base + 2);
        check("pre_redir_inst_valid", {31'd0, m_inst_valid}, 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; inst_ready = 1'b1;
        cyc();
        check("flush_inst_valid", {31'd0, m_inst_valid}, 32'd0);
        check("flush_fetch_pc", m_fetch_pc, 32'h200);
        check("flush_req_addr", m_req_addr, 32'h200);
        redirect_valid = 1'b0;
        cyc();
        check("flush_accepts", 32'(acc_cnt - base), 32'd3);
        imem_req_ready = 1'b0;
        drain();

        // Wrapping reset PC on the second instance
        do_reset(1'b1);
        imem_req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
        exp_addr_q.push_back(32'hFFFF_FFF8); exp_addr_q.push_back(32'hFFFF_FFFC); exp_addr_q.push_back(32'h0);
        exp_inst(32'hFFFF_FFF8, 32'hFFF8_BEEF); exp_inst(32'hFFFF_FFFC, 32'hFFFC_BEEF);
        exp_inst(32'h0, 32'h0000_BEEF);
        base = acc_cnt;
        wait_acc(base + 3);
        imem_req_ready = 1'b0;
        drain();
        check("wrap_fetch_pc", m_fetch_pc, 32'h4);

        // Reset in WAIT abandons the request; the stale response is ignored
        lat = 3;
        exp_addr_q.push_back(32'h4);
        imem_req_ready = 1'b1;
        base = acc_cnt;
        wait_acc(base + 1);
        reset_b = 1'b1; imem_req_ready = 1'b0;
        cyc();
        check("wait_rst_req_valid", {31'd0, m_req_valid}, 32'd0);
        check("wait_rst_inst_valid", {31'd0, m_inst_valid}, 32'd0);
        check("wait_rst_fetch_pc", m_fetch_pc, 32'hFFFF_FFF8);
        reset_b = 1'b0;
        repeat (3) begin
            cyc();
            check("stale_inst_valid", {31'd0, m_inst_valid}, 32'd0);
        end
        lat = 1;
        exp_addr_q.push_back(32'hFFFF_FFF8);
        exp_inst(32'hFFFF_FFF8, 32'hFFF8_BEEF);
        imem_req_ready = 1'b1;
        base = acc_cnt;
        wait_acc(base + 1);
        imem_req_ready = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
